// File: rtl/wb_stage_if.sv
// Write-back stage bus: memory-stage inputs, stall/flush, register-file and forwarding outputs.
// The perf-counter port exists only when WB_PERF_CNT_EN is defined.
interface wb_stage_if #(
  parameter int DATA_W = 32
`ifdef WB_PERF_CNT_EN
  , parameter int RET_CNT_W = 64
`endif
);
  logic              stall_in;
  logic              flush_in;
  logic              valid_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] read_data_in;
  logic [4:0]        rd_addr_in;
  logic [DATA_W-1:0] pc_plus_4_in;
  logic              reg_write_in;
  logic              mem_to_reg_in;
  logic              link_in;
  logic [2:0]        funct3_in;
  logic              rf_we_out;
  logic [4:0]        rf_waddr_out;
  logic [DATA_W-1:0] rf_wdata_out;
  logic              fwd_valid_out;
  logic [4:0]        fwd_rd_out;
  logic [DATA_W-1:0] fwd_data_out;
  logic              retire_out;
`ifdef WB_PERF_CNT_EN
  logic [RET_CNT_W-1:0] retire_count_out;
`endif

  modport master (
    output stall_in, flush_in, valid_in, alu_result_in, read_data_in, rd_addr_in,
           pc_plus_4_in, reg_write_in, mem_to_reg_in, link_in, funct3_in,
    input  rf_we_out, rf_waddr_out, rf_wdata_out, fwd_valid_out, fwd_rd_out,
           fwd_data_out, retire_out
`ifdef WB_PERF_CNT_EN
    , input retire_count_out
`endif
  );

  modport slave (
    input  stall_in, flush_in, valid_in, alu_result_in, read_data_in, rd_addr_in,
           pc_plus_4_in, reg_write_in, mem_to_reg_in, link_in, funct3_in,
    output rf_we_out, rf_waddr_out, rf_wdata_out, fwd_valid_out, fwd_rd_out,
           fwd_data_out, retire_out
`ifdef WB_PERF_CNT_EN
    , output retire_count_out
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB register, load formatting and write-back select; outputs one cycle after capture, stall holds, flush wins.
// WB_PERF_CNT_EN adds a wrapping retired-instruction counter.
module wb_stage #(
  parameter int DATA_W = 32
`ifdef WB_PERF_CNT_EN
  , parameter int RET_CNT_W = 64
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_stage_if.slave bus
);

  logic              r_valid;
  logic              r_written;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_link;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_pc4;
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;

  logic              w_fwd_vld;
  logic              w_we;
  logic              w_retire;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_written    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_link       <= 1'b0;
      r_alu        <= '0;
      r_rdata      <= '0;
      r_pc4        <= '0;
      r_rd         <= '0;
      r_funct3     <= '0;
    end else if (bus.flush_in) begin
      r_valid   <= 1'b0;
      r_written <= 1'b0;
    end else if (bus.stall_in) begin
      // Remember the write so a held instruction never writes twice.
      if (w_we) r_written <= 1'b1;
    end else begin
      r_valid      <= bus.valid_in;
      r_written    <= 1'b0;
      r_reg_write  <= bus.reg_write_in;
      r_mem_to_reg <= bus.mem_to_reg_in;
      r_link       <= bus.link_in;
      r_alu        <= bus.alu_result_in;
      r_rdata      <= bus.read_data_in;
      r_pc4        <= bus.pc_plus_4_in;
      r_rd         <= bus.rd_addr_in;
      r_funct3     <= bus.funct3_in;
    end
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_alu[1:0])
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(DATA_W-16){1'b0}}, w_half};
      default: w_load = r_rdata;
    endcase
    if (r_link)            w_wdata = r_pc4;
    else if (r_mem_to_reg) w_wdata = w_load;
    else                   w_wdata = r_alu;
  end

  // Forwarding stays live through a stall; only the RF write is one-shot.
  assign w_fwd_vld = r_valid & r_reg_write & (r_rd != 5'd0);
  assign w_we      = w_fwd_vld & ~r_written;
  assign w_retire  = r_valid & (~bus.stall_in | bus.flush_in);

  assign bus.rf_we_out     = w_we;
  assign bus.rf_waddr_out  = r_valid ? r_rd : 5'd0;
  assign bus.rf_wdata_out  = r_valid ? w_wdata : '0;
  assign bus.fwd_valid_out = w_fwd_vld;
  assign bus.fwd_rd_out    = r_valid ? r_rd : 5'd0;
  assign bus.fwd_data_out  = r_valid ? w_wdata : '0;
  assign bus.retire_out    = w_retire;

`ifdef WB_PERF_CNT_EN
  logic [RET_CNT_W-1:0] r_ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ret_cnt <= '0;
    else if (w_retire) r_ret_cnt <= r_ret_cnt + 1'b1;
  end

  assign bus.retire_count_out = r_ret_cnt;
`endif

endmodule
